mdu_ctrl: RTL and testbench

- Iterative multiply/divide unit with sequencing controller and HI/LO register file for the pipelined MIPS core.
- Sits beside the EX-stage ALU and takes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded ALU operation.
- Runs a shift-add or shift-subtract datapath for WIDTH cycles and writes HI/LO.
- Raises stall back to the pipeline whenever an instruction needs HI/LO or the unit while it is busy.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_ctrl_if.sv | 26 ++
 rtl/mdu_iter_core.sv | 71 +++++++
 rtl/mdu_ctrl.sv | 124 ++++++++++++
 tb/tb_mdu_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDU op codes, controller states,
// and the EX-stage ALU-op to MDU-op mapping used by the decoder.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_e;

    // ALU operation codes seen by the decoder that are routed to the MDU
    localparam logic [3:0] ALUOP_MULT  = 4'hA;
    localparam logic [3:0] ALUOP_MULTU = 4'hB;
    localparam logic [3:0] ALUOP_DIV   = 4'hC;
    localparam logic [3:0] ALUOP_DIVU  = 4'hD;
    localparam logic [3:0] ALUOP_MTHI  = 4'hE;
    localparam logic [3:0] ALUOP_MTLO  = 4'hF;

    function automatic logic [2:0] alu_to_mdu_op(input logic [3:0] alu_op);
        logic [2:0] res;
        res = 3'b111;
        case (alu_op)
            ALUOP_MULT:  res = MDU_MULT;
            ALUOP_MULTU: res = MDU_MULTU;
            ALUOP_DIV:   res = MDU_DIV;
            ALUOP_DIVU:  res = MDU_DIVU;
            ALUOP_MTHI:  res = MDU_MTHI;
            ALUOP_MTLO:  res = MDU_MTLO;
            default:     res = 3'b111;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU connection: op issue, MFHI/MFLO request, status and HI/LO.
interface mdu_ctrl_if #(parameter int unsigned WIDTH = 32);
    import mdu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mf_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, mf_req,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, mf_req,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/mdu_iter_core.sv
// Iteration datapath: 2*WIDTH accumulator with shift-add multiply and restoring
// shift-subtract divide steps, plus the iteration counter.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_try;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply keeps the multiplier in acc_lo and shifts the partial product in
    // from the top; divide shifts dividend bits out of acc_lo into the remainder.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_try = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (rem_try >= {1'b0, opnd});
        diff    = rem_try[WIDTH-1:0] - opnd;
    end

    assign last = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (load) begin
            count    <= CW'(WIDTH - 1);
            div_mode <= is_div;
            acc_hi   <= '0;
            acc_lo   <= is_div ? a : b;
            opnd     <= is_div ? b : a;
        end else if (step) begin
            count <= count - 1'b1;
            if (div_mode) begin
                if (fits) begin
                    acc_hi <= diff;
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= rem_try[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller with HI/LO registers and pipeline stall.
// Signed ops iterate on magnitudes; the sign fix is applied on the FIX->IDLE edge.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    mdu_ctrl_if.slave   bus
);

    mdu_state_e       state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div_q;
    logic             sign_q;
    logic             sign_r;

    logic             is_arith;
    logic             op_div;
    logic             op_signed;
    logic             div_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Divide by zero keeps the raw dividend so the remainder comes out as rs_val.
    always_comb begin
        is_arith  = (bus.op[2] == 1'b0);
        op_div    = bus.op[1];
        op_signed = ~bus.op[0];
        div_zero  = op_div & (bus.rt_val == '0);
        a_neg     = op_signed & bus.rs_val[WIDTH-1] & ~div_zero;
        b_neg     = op_signed & bus.rt_val[WIDTH-1];
        a_in      = a_neg ? -bus.rs_val : bus.rs_val;
        b_in      = b_neg ? -bus.rt_val : bus.rt_val;
        load      = (state == IDLE) & bus.start & is_arith;
        step      = (state == RUN);
        prod_fix  = sign_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = sign_q ? -acc_lo : acc_lo;
        rem_fix   = sign_r ? -acc_hi : acc_hi;
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (op_div),
        .a      (a_in),
        .b      (b_in),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                state    <= RUN;
                                busy_q   <= 1'b1;
                                is_div_q <= op_div;
                                sign_q   <= a_neg ^ b_neg;
                                sign_r   <= a_neg;
                            end
                            MDU_MTHI: hi_q <= bus.rs_val;
                            MDU_MTLO: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (last) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = busy_q & (bus.start | bus.mf_req);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic results, latency, stall, MT ops and reset abort.
module tb_mdu_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues an op at the next edge and waits for done; returns in the done cycle.
    // hold keeps an MTLO 0x0BAD0BAD presented while busy, as a stalled instruction would be.
    task automatic issue_wait(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input int mf_delay, input bit hold,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int edges;
        bit bad;
        bit exp_stall;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = hold;
        if (hold) begin
            bus.op     = 3'b101;
            bus.rs_val = 32'h0BAD0BAD;
        end
        edges = 1;
        bad   = 1'b0;
        check({tag, " busy"}, {63'd0, bus.busy}, 64'd1);
        while (bus.done !== 1'b1 && edges < 100) begin
            bus.mf_req = (edges >= mf_delay);
            exp_stall  = hold || (edges >= mf_delay);
            #1;
            if (bus.stall !== exp_stall || bus.busy !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'd34);
        check({tag, " stall_track"}, {63'd0, bad}, 64'd0);
        bus.mf_req = 1'b1;
        #1;
        check({tag, " done_stall"}, {63'd0, bus.stall}, 64'd0);
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        bus.mf_req = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue_wait(tag, op, a, b, 1, 1'b0, exp_hi, exp_lo);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mf_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst hi", {32'd0, bus.hi}, 64'd0);
        check("rst lo", {32'd0, bus.lo}, 64'd0);
        check("rst busy", {63'd0, bus.busy}, 64'd0);
        check("rst done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;
        bus.mf_req = 1'b1;
        #1;
        check("idle mf no stall", {63'd0, bus.stall}, 64'd0);
        bus.mf_req = 1'b0;
        @(posedge clk); #1;

        // Stalled instruction held through the run, accepted in the done cycle
        issue_wait("mult6x7", 3'b000, 32'd6, 32'd7, 100, 1'b1, 32'h0, 32'h2A);
        check("held start stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("held mtlo lo", {32'd0, bus.lo}, 64'h0BAD0BAD);
        check("held mtlo hi", {32'd0, bus.hi}, 64'h0);
        check("held mtlo busy", {63'd0, bus.busy}, 64'd0);
        check("held done pulse", {63'd0, bus.done}, 64'd0);

        run_op("mult_neg",  3'b000, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_neg", 3'b001, 32'hFFFFFFF9, 32'd3, 32'h00000002, 32'hFFFFFFEB);
        run_op("mult_min",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("div100_7",  3'b010, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m7_2",  3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div7_m2",   3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("divu_z",    3'b011, 32'h1234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
        run_op("div_negz",  3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_op("divu_big",  3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);

        // MFHI five cycles in, then a second MULT issued straight from the done cycle
        issue_wait("mf5", 3'b000, 32'd6, 32'd7, 5, 1'b0, 32'h0, 32'h2A);
        run_op("b2b", 3'b000, 32'h00010000, 32'h00010000, 32'h1, 32'h0);

        bus.op     = 3'b110;
        bus.rs_val = 32'h55555555;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("rsvd busy", {63'd0, bus.busy}, 64'd0);
        check("rsvd hi", {32'd0, bus.hi}, 64'h1);
        check("rsvd lo", {32'd0, bus.lo}, 64'h0);

        bus.op     = 3'b100;
        bus.rs_val = 32'hCAFEF00D;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.op     = 3'b101;
        bus.rs_val = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("mthi hi", {32'd0, bus.hi}, 64'hCAFEF00D);
        check("mtlo lo", {32'd0, bus.lo}, 64'hDEADBEEF);
        check("mt busy", {63'd0, bus.busy}, 64'd0);
        check("mt done", {63'd0, bus.done}, 64'd0);

        bus.op     = 3'b010;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort busy_before", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {63'd0, bus.busy}, 64'd0);
        check("abort hi", {32'd0, bus.hi}, 64'd0);
        check("abort lo", {32'd0, bus.lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        check("abort no_done", 64'(done_cnt), 64'd0);
        check("abort idle", {63'd0, bus.busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
